// File: rtl/vga_sync_gen.sv
// Pixel-timing generator for the parallax VGA demo: raster counters, sync/enable decode,
// line and frame strobes, and a completed-frame counter for the scroll effect.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 40,
  parameter int H_BACK    = 128,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 9,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 28,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit bounds so a total of exactly 1024 still compares correctly against 10-bit counts.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       line_wrap;
  logic       frame_wrap;
  logic       hsync_next;
  logic       vsync_next;
  logic       de_next;

  function automatic logic in_window(input logic [9:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  // Next raster position, decoded ahead so the registered syncs line up with x/y.
  always_comb begin
    x_next     = x;
    y_next     = y;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if ({1'b0, x} == H_LAST) begin
      x_next    = 10'd0;
      line_wrap = 1'b1;
      if ({1'b0, y} == V_LAST) begin
        y_next     = 10'd0;
        frame_wrap = 1'b1;
      end else begin
        y_next = y + 10'd1;
      end
    end else begin
      x_next = x + 10'd1;
    end
    hsync_next = in_window(x_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_next = in_window(y_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    de_next    = ({1'b0, x_next} < H_VIS) && ({1'b0, y_next} < V_VIS);
  end

  // Strobes clear every clock so they stay one wb_clk_i wide whatever the pix_en duty.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x           <= 10'd0;
      y           <= 10'd0;
      frame       <= '0;
      de          <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= x_next;
        y           <= y_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        de          <= de_next;
        line_start  <= line_wrap;
        frame_start <= frame_wrap;
        if (frame_wrap) begin
          frame <= frame + FRAME_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three instances (default, tiny with 2-bit frame,
// and a small active-high-sync raster) checked cycle by cycle plus directed timing checks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fr;
  } obs_t;

  typedef struct {
    int   id;
    obs_t exp;
  } sb_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a, en_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic rst_b, en_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic rst_c, en_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [7:0] fr_a;
  logic [1:0] fr_b;
  logic [3:0] fr_c;

  int hvis[3], hfp[3], hsw[3], hbp[3], vvis[3], vfp[3], vsw[3], vbp[3], fw[3];
  bit spol[3];
  int ticks[3];
  sb_t sbq[$];
  int tests = 0;
  int failed = 0;

  vga_sync_gen dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .pix_en(en_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .frame(fr_a)
  );

  vga_sync_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .FRAME_W(2)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .pix_en(en_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .frame(fr_b)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b1), .FRAME_W(4)
  ) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst_c), .pix_en(en_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c), .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c), .frame(fr_c)
  );

  // Expected outputs after n pix_en ticks since reset, derived from the tick count alone.
  function automatic obs_t model(input int id, input int n, input bit adv);
    obs_t o;
    int ht, vt, hx, vy;
    ht = hvis[id] + hfp[id] + hsw[id] + hbp[id];
    vt = vvis[id] + vfp[id] + vsw[id] + vbp[id];
    hx = n % ht;
    vy = (n / ht) % vt;
    o.x  = 10'(hx);
    o.y  = 10'(vy);
    o.hs = (hx >= hvis[id] + hfp[id] && hx < hvis[id] + hfp[id] + hsw[id]) ? spol[id] : ~spol[id];
    o.vs = (vy >= vvis[id] + vfp[id] && vy < vvis[id] + vfp[id] + vsw[id]) ? spol[id] : ~spol[id];
    o.de = (hx < hvis[id]) && (vy < vvis[id]);
    o.ls = adv && (hx == 0);
    o.fs = adv && (hx == 0) && (vy == 0);
    o.fr = 8'((n / (ht * vt)) % (1 << fw[id]));
    return o;
  endfunction

  function automatic obs_t actual(input int id);
    obs_t o;
    o = '0;
    case (id)
      0: begin
        o.x = x_a; o.y = y_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a;
        o.ls = ls_a; o.fs = fs_a; o.fr = fr_a;
      end
      1: begin
        o.x = x_b; o.y = y_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b;
        o.ls = ls_b; o.fs = fs_b; o.fr = {6'd0, fr_b};
      end
      default: begin
        o.x = x_c; o.y = y_c; o.hs = hs_c; o.vs = vs_c; o.de = de_c;
        o.ls = ls_c; o.fs = fs_c; o.fr = {4'd0, fr_c};
      end
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one clock of stimulus for one instance and queues the response it must show.
  task automatic applyStimulus(input int id, input bit en, input bit r);
    bit adv;
    @(negedge clk);
    case (id)
      0: begin en_a = en; rst_a = r; end
      1: begin en_b = en; rst_b = r; end
      default: begin en_c = en; rst_c = r; end
    endcase
    adv = 1'b0;
    if (r) begin
      ticks[id] = 0;
    end else if (en) begin
      ticks[id]++;
      adv = 1'b1;
    end
    sbq.push_back('{id, model(id, ticks[id], adv)});
    @(posedge clk);
    #3;
  endtask

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput($sformatf("scoreboard dut%0d", e.id), 64'(actual(e.id)), 64'(e.exp));
      end
    end
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_low, first_x, n_de, de_fall_x, ls_first, ls_gap, line_ticks, got;
    int n_vs, vs_x, vs_y, fs_first, fs_gap, fr_first, nfs;
    int fr_seq[4];
    int exp_seq[4];

    hvis = '{640, 4, 16}; hfp = '{24, 1, 2}; hsw = '{40, 1, 3}; hbp = '{128, 2, 3};
    vvis = '{480, 2, 6};  vfp = '{9, 1, 2};  vsw = '{3, 1, 2};   vbp = '{28, 1, 2};
    fw = '{8, 2, 4};
    spol = '{1'b0, 1'b0, 1'b1};
    ticks = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      assert (hvis[i] + hfp[i] + hsw[i] + hbp[i] <= 1024)
        else $fatal(1, "[TB] H_TOTAL exceeds 1024");
    end

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1;  en_b = 1'b0;  en_c = 1'b0;
    repeat (2) @(posedge clk);
    #3;

    // Reset values with pix_en high
    checkOutput("reset_x", 64'(x_a), 0);
    checkOutput("reset_y", 64'(y_a), 0);
    checkOutput("reset_de", 64'(de_a), 1);
    checkOutput("reset_hsync", 64'(hs_a), 1);
    checkOutput("reset_vsync", 64'(vs_a), 1);
    checkOutput("reset_frame", 64'(fr_a), 0);
    checkOutput("reset_ls", 64'(ls_a), 0);
    checkOutput("reset_fs", 64'(fs_a), 0);
    repeat (10) applyStimulus(0, 1'b1, 1'b1);
    checkOutput("reset_hold_x", 64'(x_a), 0);
    checkOutput("reset_hold_hsync", 64'(hs_a), 1);

    // Horizontal timing at default raster
    n_low = 0; first_x = -1; n_de = 0; de_fall_x = -1; ls_first = -1; ls_gap = -1;
    for (int i = 1; i <= 1700; i++) begin
      applyStimulus(0, 1'b1, 1'b0);
      if (i <= 832) begin
        if (hs_a == 1'b0) begin
          n_low++;
          if (first_x < 0) first_x = int'(x_a);
        end
        if (de_a) n_de++;
        if (!de_a && de_fall_x < 0) de_fall_x = int'(x_a);
      end
      if (ls_a) begin
        if (ls_first < 0) ls_first = i;
        else if (ls_gap < 0) ls_gap = i - ls_first;
      end
    end
    checkOutput("hsync_low_len", 64'(n_low), 40);
    checkOutput("hsync_start_x", 64'(first_x), 664);
    checkOutput("de_fall_x", 64'(de_fall_x), 640);
    checkOutput("de_high_count", 64'(n_de), 640);
    checkOutput("line_start_first", 64'(ls_first), 832);
    checkOutput("line_start_gap", 64'(ls_gap), 832);

    // Clock-enable stalls
    checkOutput("stall_x0", 64'(x_a), 36);
    checkOutput("stall_y0", 64'(y_a), 2);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("stall_x1", 64'(x_a), 37);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("stall_hold", 64'(x_a), 37);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("stall_x2", 64'(x_a), 38);
    repeat (793) applyStimulus(0, 1'b1, 1'b0);
    checkOutput("pre_wrap_x", 64'(x_a), 831);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("wrap_ls", 64'(ls_a), 1);
    checkOutput("wrap_y", 64'(y_a), 3);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("wrap_ls_width", 64'(ls_a), 0);
    checkOutput("wrap_x_hold", 64'(x_a), 0);
    line_ticks = 0; got = 0;
    for (int k = 0; k < 4000 && got == 0; k++) begin
      bit en;
      en = (k % 4 == 0) || (k % 4 == 3);
      applyStimulus(0, en, 1'b0);
      if (en) line_ticks++;
      if (ls_a) got = 1;
    end
    checkOutput("line_seen", 64'(got), 1);
    checkOutput("line_ticks", 64'(line_ticks), 832);
    en_a = 1'b0;

    // Vertical timing and frame strobe on the small active-high raster
    applyStimulus(2, 1'b0, 1'b0);
    n_vs = 0; vs_x = -1; vs_y = -1; fs_first = -1; fs_gap = -1; fr_first = -1;
    for (int i = 1; i <= 600; i++) begin
      applyStimulus(2, 1'b1, 1'b0);
      if (i <= 288 && vs_c) begin
        n_vs++;
        if (vs_x < 0) begin
          vs_x = int'(x_c);
          vs_y = int'(y_c);
        end
      end
      if (fs_c) begin
        if (fs_first < 0) begin
          fs_first = i;
          fr_first = int'(fr_c);
        end else if (fs_gap < 0) begin
          fs_gap = i - fs_first;
        end
      end
    end
    checkOutput("vsync_active_len", 64'(n_vs), 48);
    checkOutput("vsync_start_x", 64'(vs_x), 0);
    checkOutput("vsync_start_y", 64'(vs_y), 8);
    checkOutput("frame_start_first", 64'(fs_first), 288);
    checkOutput("frame_start_gap", 64'(fs_gap), 288);
    checkOutput("frame_at_first_fs", 64'(fr_first), 1);

    // Frame counter wrap with a 2-bit frame
    applyStimulus(1, 1'b0, 1'b0);
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0;
    fr_seq[0] = -1; fr_seq[1] = -1; fr_seq[2] = -1; fr_seq[3] = -1;
    nfs = 0;
    for (int i = 1; i <= 160; i++) begin
      applyStimulus(1, 1'b1, 1'b0);
      if (fs_b) begin
        if (nfs < 4) fr_seq[nfs] = int'(fr_b);
        nfs++;
      end
    end
    checkOutput("frame_wrap_pulses", 64'(nfs), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("frame_wrap_seq%0d", k), 64'(fr_seq[k]), 64'(exp_seq[k]));
    end

    // Asynchronous reset in the middle of both sync pulses
    applyStimulus(2, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b0);
    repeat (211) applyStimulus(2, 1'b1, 1'b0);
    checkOutput("mid_x", 64'(x_c), 19);
    checkOutput("mid_y", 64'(y_c), 8);
    checkOutput("mid_hsync", 64'(hs_c), 1);
    checkOutput("mid_vsync", 64'(vs_c), 1);
    #2;
    rst_c = 1'b1;
    #2;
    checkOutput("async_x", 64'(x_c), 0);
    checkOutput("async_y", 64'(y_c), 0);
    checkOutput("async_de", 64'(de_c), 1);
    checkOutput("async_hsync", 64'(hs_c), 0);
    checkOutput("async_vsync", 64'(vs_c), 0);
    checkOutput("async_ls", 64'(ls_c), 0);
    checkOutput("async_fs", 64'(fs_c), 0);
    checkOutput("async_frame", 64'(fr_c), 0);
    applyStimulus(2, 1'b1, 1'b1);
    applyStimulus(2, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b0);
    checkOutput("release_x", 64'(x_c), 0);
    checkOutput("release_ls", 64'(ls_c), 0);
    applyStimulus(2, 1'b1, 1'b0);
    checkOutput("restart_x", 64'(x_c), 1);
    checkOutput("restart_y", 64'(y_c), 0);

    repeat (2) @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
